// File: rtl/button_debouncer.sv
// Push-button debouncer sampled on rising edges of a divided strobe from the clock divider.
// Produces a debounced level plus registered press, release, long-press and auto-repeat pulses.
module button_debouncer #(
   parameter int STABLE_SAMPLES = 4,
   parameter int LONG_SAMPLES   = 500,
   parameter int REPEAT_SAMPLES = 100,
   parameter int CNT_W          = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic slow_clk,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   typedef enum logic [1:0] {
      S_RELEASED,
      S_PRESS_PEND,
      S_PRESSED,
      S_RELEASE_PEND
   } state_t;

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_SAMPLES);
   localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_SAMPLES);
   localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_SAMPLES);

   state_t           state_q;
   logic             sync1_q, sync2_q, slow_prev_q;
   logic [CNT_W-1:0] stab_cnt_q, hold_cnt_q, rep_cnt_q;
   logic             level_q, press_q, release_q, long_q, repeat_q;

   logic             btn_s, tick;
   logic [CNT_W-1:0] stab_inc, hold_inc, rep_inc;

   assign btn_s    = sync2_q;
   assign tick     = slow_clk & ~slow_prev_q;
   assign stab_inc = stab_cnt_q + 1'b1;
   assign hold_inc = hold_cnt_q + 1'b1;
   assign rep_inc  = rep_cnt_q + 1'b1;

   // stab_cnt is zero on entry to RELEASED and PRESSED, so stab_inc==STABLE_C also covers STABLE_SAMPLES==1.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_RELEASED;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         slow_prev_q <= 1'b1;
         stab_cnt_q  <= '0;
         hold_cnt_q  <= '0;
         rep_cnt_q   <= '0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         repeat_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere so every branch reads the pre-edge values of all registers.
         sync1_q     <= btn_raw;
         sync2_q     <= sync1_q;
         slow_prev_q <= slow_clk;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         repeat_q    <= 1'b0;

         if (tick) begin
            case (state_q)
               S_RELEASED, S_PRESS_PEND: begin
                  if (!btn_s) begin
                     state_q    <= S_RELEASED;
                     stab_cnt_q <= '0;
                  end else if (stab_inc == STABLE_C) begin
                     state_q    <= S_PRESSED;
                     stab_cnt_q <= '0;
                     hold_cnt_q <= '0;
                     rep_cnt_q  <= '0;
                     level_q    <= 1'b1;
                     press_q    <= 1'b1;
                  end else begin
                     state_q    <= S_PRESS_PEND;
                     stab_cnt_q <= stab_inc;
                  end
               end

               S_PRESSED, S_RELEASE_PEND: begin
                  if (btn_s && state_q == S_RELEASE_PEND) begin
                     state_q    <= S_PRESSED;
                     stab_cnt_q <= '0;
                  end else if (btn_s) begin
                     if (hold_cnt_q != LONG_C) begin
                        hold_cnt_q <= hold_inc;
                        if (hold_inc == LONG_C) begin
                           long_q    <= 1'b1;
                           rep_cnt_q <= '0;
                        end
                     end else if (rep_inc == REPEAT_C) begin
                        repeat_q  <= 1'b1;
                        rep_cnt_q <= '0;
                     end else begin
                        rep_cnt_q <= rep_inc;
                     end
                  end else if (stab_inc == STABLE_C) begin
                     state_q    <= S_RELEASED;
                     stab_cnt_q <= '0;
                     hold_cnt_q <= '0;
                     rep_cnt_q  <= '0;
                     level_q    <= 1'b0;
                     release_q  <= 1'b1;
                  end else begin
                     state_q    <= S_RELEASE_PEND;
                     stab_cnt_q <= stab_inc;
                  end
               end

               default: begin
                  state_q    <= S_RELEASED;
                  stab_cnt_q <= '0;
                  hold_cnt_q <= '0;
                  rep_cnt_q  <= '0;
                  level_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: each stimulus tick queues the pulse it should cause,
// and a monitor pops and compares kind, cycle and level whenever any pulse appears.
module tb_button_debouncer;

   localparam logic [3:0] K_NONE  = 4'b0000;
   localparam logic [3:0] K_PRESS = 4'b1000;
   localparam logic [3:0] K_REL   = 4'b0100;
   localparam logic [3:0] K_LONG  = 4'b0010;
   localparam logic [3:0] K_REP   = 4'b0001;

   typedef struct {
      logic [3:0] kind;
      int         cyc;
      logic       level;
   } exp_t;

   logic clock = 1'b0;
   logic reset, slow_clk, btn_raw;
   logic btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

   exp_t q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   button_debouncer #(
      .STABLE_SAMPLES(4),
      .LONG_SAMPLES  (10),
      .REPEAT_SAMPLES(3),
      .CNT_W         (16)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .slow_clk     (slow_clk),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One slow_clk period (16 clocks). The rising edge lands on a negedge, so the very next
   // posedge is the deciding tick and any pulse is visible just after it.
   task automatic tick(input logic b, input logic [3:0] exp_kind, input logic exp_level,
                       input bit toggle = 1'b0);
      exp_t e;
      @(negedge clock);
      slow_clk = 1'b0;
      btn_raw  = b;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         if (toggle && i < 4) btn_raw = ~btn_raw;
         else                 btn_raw = b;
      end
      @(negedge clock);
      slow_clk = 1'b1;
      if (exp_kind != K_NONE) begin
         e.kind  = exp_kind;
         e.cyc   = cyc + 1;
         e.level = exp_level;
         q.push_back(e);
      end
      repeat (7) @(negedge clock);
   endtask

   initial begin : monitor
      logic [3:0] obs;
      exp_t       e;
      forever begin
         @(posedge clock);
         cyc++;
         #1;
         obs = {press_pulse, release_pulse, long_pulse, repeat_pulse};
         if (obs != K_NONE) begin
            if (q.size() == 0) begin
               check("unexpected_pulse", 32'(obs), 32'(K_NONE));
            end else begin
               e = q.pop_front();
               check("pulse_kind", 32'(obs), 32'(e.kind));
               check("pulse_cycle", cyc, e.cyc);
               check("pulse_level", 32'(btn_level), 32'(e.level));
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [3:0] k;
      logic [6:0] bounce;
      reset    = 1'b1;
      slow_clk = 1'b0;
      btn_raw  = 1'b0;
      repeat (4) @(negedge clock);
      check("reset_outputs", {27'd0, btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}, 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      // Clean press, then hold: long at hold 10, repeats at 13, 16, 19.
      for (int i = 1; i <= 4; i++) tick(1'b1, (i == 4) ? K_PRESS : K_NONE, 1'b1);
      check("press_level", 32'(btn_level), 32'd1);
      for (int h = 1; h <= 20; h++) begin
         if (h == 10)                          k = K_LONG;
         else if (h > 10 && (h - 10) % 3 == 0) k = K_REP;
         else                                  k = K_NONE;
         tick(1'b1, k, 1'b1);
      end
      check("hold_queue_empty", q.size(), 0);

      // Release with a one-tick glitch high while pending.
      tick(1'b0, K_NONE, 1'b1);
      check("rel_pend_level", 32'(btn_level), 32'd1);
      tick(1'b1, K_NONE, 1'b1);
      check("glitch_level", 32'(btn_level), 32'd1);
      for (int i = 1; i <= 4; i++) tick(1'b0, (i == 4) ? K_REL : K_NONE, 1'b0);
      check("release_level", 32'(btn_level), 32'd0);
      check("release_queue_empty", q.size(), 0);

      // Bounce 1,1,0,1,1,1,1: a single press on the seventh tick.
      bounce = 7'b1111011;
      for (int i = 0; i < 7; i++) tick(bounce[i], (i == 6) ? K_PRESS : K_NONE, 1'b1);
      check("bounce_level", 32'(btn_level), 32'd1);
      tick(1'b1, K_NONE, 1'b1);
      tick(1'b1, K_NONE, 1'b1);

      // Reset mid-PRESSED: outputs clear at once, no release pulse afterwards.
      @(negedge clock);
      reset   = 1'b1;
      btn_raw = 1'b0;
      #1;
      check("midreset_outputs", {27'd0, btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}, 32'd0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick(1'b0, K_NONE, 1'b0);
      check("post_reset_level", 32'(btn_level), 32'd0);
      check("post_reset_queue_empty", q.size(), 0);

      // slow_clk high across reset release: no tick until a fresh rising edge.
      @(negedge clock);
      slow_clk = 1'b1;
      reset    = 1'b1;
      repeat (3) @(negedge clock);
      reset   = 1'b0;
      btn_raw = 1'b1;
      repeat (80) @(negedge clock);
      check("slow_high_level", 32'(btn_level), 32'd0);

      // Clock-rate toggling between ticks, samples low at every tick.
      for (int i = 0; i < 6; i++) tick(1'b0, K_NONE, 1'b0, 1'b1);
      check("toggle_level", 32'(btn_level), 32'd0);

      // Stuck slow_clk: button held, nothing happens; then ticks resume and a press is seen.
      @(negedge clock);
      slow_clk = 1'b0;
      btn_raw  = 1'b1;
      repeat (100) @(negedge clock);
      check("stuck_level", 32'(btn_level), 32'd0);
      for (int i = 1; i <= 4; i++) tick(1'b1, (i == 4) ? K_PRESS : K_NONE, 1'b1);
      check("recover_level", 32'(btn_level), 32'd1);
      repeat (4) @(negedge clock);
      check("final_queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
